// File: rtl/nes_joypad_poller.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_poller
// Purpose  : Periodically scans an external NES (4021) controller over
//            latch/clock/data and publishes a filtered active-high button
//            vector. Optional autofire gating: define JOYPAD_AUTOFIRE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nes_joypad_poller #(
    parameter int CLK_HZ      = 21428571,
    parameter int POLL_HZ     = 60,
    parameter int PULSE_US    = 6,
    parameter int AUTOFIRE_HZ = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad_data,
    input  logic [7:0] autofire_mask,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam logic [31:0] c_T    = 32'(CLK_HZ * PULSE_US / 1000000);
    localparam logic [31:0] c_POLL = 32'(CLK_HZ / POLL_HZ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW0  = 3'd2;
    localparam logic [2:0] S_CLKH  = 3'd3;
    localparam logic [2:0] S_CLKL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_tcnt;
    logic [31:0] r_poll;
    logic [2:0]  r_idx;
    logic [6:0]  r_shift;
    logic [1:0]  r_sync;
    logic [7:0]  r_buttons;
    logic        r_valid;
    logic        w_tlast;
    logic        w_sd;
    logic [7:0]  w_raw;
    logic [7:0]  w_filt;
    logic [7:0]  w_af_kill;

    assign w_sd          = r_sync[1];
    assign w_tlast       = (r_tcnt == c_T - 32'd1);
    assign buttons       = r_buttons;
    assign buttons_valid = r_valid;

    // The final bit is merged straight from the synchronizer so the vector
    // can be published on the same edge the last sample is taken.
    assign w_raw = {~w_sd, r_shift};

    always_comb begin
        w_filt = w_raw;
        if (w_raw[4] && w_raw[5]) w_filt[5:4] = 2'b00;
        if (w_raw[6] && w_raw[7]) w_filt[7:6] = 2'b00;
    end

`ifdef JOYPAD_AUTOFIRE_EN
    localparam logic [31:0] c_AF = 32'(CLK_HZ / (2 * AUTOFIRE_HZ));

    logic [31:0] r_af_cnt;
    logic        r_af_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_af_cnt   <= 32'd0;
            r_af_phase <= 1'b0;
        end else if (r_af_cnt == c_AF - 32'd1) begin
            r_af_cnt   <= 32'd0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + 32'd1;
        end
    end

    assign w_af_kill = autofire_mask & {8{r_af_phase}};
`else
    localparam int c_unused_af_hz = AUTOFIRE_HZ;
    logic w_unused_mask;
    assign w_unused_mask = ^autofire_mask;
    assign w_af_kill     = 8'h00;
`endif

    always_comb begin
        w_state_nxt = r_state;
        pad_latch   = 1'b0;
        pad_clk     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable && (r_poll == c_POLL - 32'd1)) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                pad_latch = 1'b1;
                if (w_tlast) w_state_nxt = S_LOW0;
            end
            S_LOW0: begin
                if (w_tlast) w_state_nxt = S_CLKH;
            end
            S_CLKH: begin
                pad_clk = 1'b1;
                if (w_tlast) w_state_nxt = S_CLKL;
            end
            S_CLKL: begin
                if (w_tlast) w_state_nxt = (r_idx == 3'd7) ? S_DONE : S_CLKH;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tcnt    <= 32'd0;
            r_poll    <= 32'd0;
            r_idx     <= 3'd0;
            r_shift   <= 7'd0;
            r_sync    <= 2'b11;
            r_buttons <= 8'h00;
            r_valid   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], pad_data};
            r_state <= w_state_nxt;
            r_valid <= 1'b0;

            if (!enable || (r_poll == c_POLL - 32'd1)) r_poll <= 32'd0;
            else                                       r_poll <= r_poll + 32'd1;

            if ((r_state == S_IDLE) || (w_state_nxt != r_state)) r_tcnt <= 32'd0;
            else                                                 r_tcnt <= r_tcnt + 32'd1;

            if ((r_state == S_LOW0) && w_tlast) begin
                r_shift[0] <= ~w_sd;
                r_idx      <= 3'd1;
            end

            if ((r_state == S_CLKL) && w_tlast) begin
                if (r_idx == 3'd7) begin
                    r_buttons <= w_filt & ~w_af_kill;
                    r_valid   <= 1'b1;
                    r_idx     <= 3'd0;
                end else begin
                    r_shift[r_idx] <= ~w_sd;
                    r_idx          <= r_idx + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_joypad_poller
// Purpose  : Self-checking bench with a behavioural 4021 controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_joypad_poller;

    localparam int CLK_HZ      = 1000000;
    localparam int POLL_HZ     = 1000;
    localparam int PULSE_US    = 2;
    localparam int AUTOFIRE_HZ = 100;
    localparam int T           = 2;
    localparam int POLL        = 1000;
    localparam int AF_HALF     = 5000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pad_data;
    logic [7:0] autofire_mask = 8'h00;
    logic       pad_latch, pad_clk, buttons_valid, busy;
    logic [7:0] buttons;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Controller model: parallel load on latch, shift on clock rise.
    logic [7:0] pressed = 8'h00;
    logic [7:0] snap    = 8'h00;
    logic       tie     = 1'b0;
    int         pidx    = 0;

    nes_joypad_poller #(
        .CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ), .PULSE_US(PULSE_US), .AUTOFIRE_HZ(AUTOFIRE_HZ)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .pad_data(pad_data),
        .autofire_mask(autofire_mask), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .buttons(buttons), .buttons_valid(buttons_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    always @(posedge pad_latch) begin
        snap = pressed;
        pidx = 0;
    end
    always @(posedge pad_clk) pidx = pidx + 1;

    assign pad_data = tie ? 1'b1 : ((pidx < 8) ? ~snap[pidx[2:0]] : 1'b1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: timed out", tag);
    endtask

    // Expected published vector, from the pressed set and the cycle count
    // since reset release at the publishing edge.
    function automatic logic [7:0] ref_buttons(input logic [7:0] p, input int c);
        logic [7:0] r;
        r = p;
        if (p[4] && p[5]) r = r & 8'hCF;
        if (p[6] && p[7]) r = r & 8'h3F;
`ifdef JOYPAD_AUTOFIRE_EN
        if ((((c - 1) / AF_HALF) % 2) == 1) r = r & ~autofire_mask;
`else
        if (c < 0) r = 8'h00;
`endif
        return r;
    endfunction

    task automatic wait_latch(input int budget, output int n);
        n = 0;
        while (!pad_latch && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!pad_latch) timeout("latch_wait");
    endtask

    // Called on the first sampled cycle with pad_latch high.
    task automatic measure_scan(input string tag);
        int lat = 0, lhi = 0, chi = 0, pulses = 0;
        logic prev_clk = 1'b0;
        while (!buttons_valid && lat < 200) begin
            if (pad_latch) lhi++;
            if (pad_clk) chi++;
            if (pad_clk && !prev_clk) pulses++;
            prev_clk = pad_clk;
            @(negedge clock);
            lat++;
        end
        if (!buttons_valid) begin
            timeout({tag, "_valid"});
        end else begin
            chk({tag, "_latency"}, lat, 16 * T);
            chk({tag, "_latch_w"}, lhi, T);
            chk({tag, "_pulses"}, pulses, 7);
            chk({tag, "_clk_hi"}, chi, 7 * T);
            chk({tag, "_buttons"}, {24'd0, buttons}, {24'd0, ref_buttons(snap, cyc)});
        end
        @(negedge clock);
        chk({tag, "_valid_1cyc"}, {31'd0, buttons_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n, vcount;
        logic [7:0] exp_hold;

        enable = 1'b1;
        pad_data_init: begin end
        repeat (3) @(negedge clock);
        chk("rst_latch", {31'd0, pad_latch}, 32'd0);
        chk("rst_clk", {31'd0, pad_clk}, 32'd0);
        chk("rst_buttons", {24'd0, buttons}, 32'd0);
        chk("rst_valid", {31'd0, buttons_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // First scan: A and Right
        pressed = 8'h81;
        reset = 1'b0;
        wait_latch(POLL + 100, n);
        chk("first_scan_delay", n, POLL);
        if (pad_latch) measure_scan("s1");

        // Up+Down+Start: opposite directions cancel
        pressed = 8'h38;
        wait_latch(POLL + 100, n);
        if (pad_latch) measure_scan("s2");

        pressed = 8'hC3;
        wait_latch(POLL + 100, n);
        if (pad_latch) measure_scan("s_lr");

        for (int i = 0; i < 6; i++) begin
            pressed = 8'($urandom);
            wait_latch(POLL + 100, n);
            if (pad_latch) measure_scan("s_rand");
        end

        // Disconnected pad
        tie = 1'b1;
        vcount = 0;
        for (int i = 0; i < 3 * POLL; i++) begin
            @(negedge clock);
            if (buttons_valid) begin
                vcount++;
                chk("tied_buttons", {24'd0, buttons}, 32'd0);
            end
        end
        chk("tied_valid_count", vcount, 3);
        tie = 1'b0;

        // Enable dropped mid-scan
        pressed = 8'($urandom);
        wait_latch(POLL + 100, n);
        repeat (10) @(negedge clock);
        enable = 1'b0;
        n = 0;
        while (!buttons_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!buttons_valid) timeout("dis_valid");
        exp_hold = ref_buttons(snap, cyc);
        chk("dis_buttons", {24'd0, buttons}, {24'd0, exp_hold});
        vcount = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (pad_latch) vcount++;
        end
        chk("dis_no_latch", vcount, 0);
        chk("dis_hold", {24'd0, buttons}, {24'd0, exp_hold});

        // Reset during CLKH
        enable = 1'b1;
        pressed = 8'h81;
        wait_latch(POLL + 100, n);
        chk("reenable_delay", n, POLL);
        n = 0;
        while (!pad_clk && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!pad_clk) timeout("clkh_wait");
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_clk", {31'd0, pad_clk}, 32'd0);
        chk("mid_rst_latch", {31'd0, pad_latch}, 32'd0);
        chk("mid_rst_buttons", {24'd0, buttons}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, buttons_valid}, 32'd0);
        reset = 1'b0;
        wait_latch(POLL + 100, n);
        chk("post_rst_delay", n, POLL);
        if (pad_latch) measure_scan("s_post_rst");

        // Autofire on A
        pressed = 8'h01;
        autofire_mask = 8'h01;
        for (int i = 0; i < 10; i++) begin
            wait_latch(POLL + 100, n);
            if (pad_latch) measure_scan("s_af");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
